// File: rtl/div_iter.sv
// Radix-2 restoring integer divider with a parametrised width, word mode, early-out for
// divide-by-zero and signed overflow, and ready/valid handshakes on both sides.
module div_iter #(
    parameter int XLEN = 64,
    parameter int WLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_flush,
    input  logic            div_valid,
    output logic            div_i_ready,
    input  logic            div_signed,
    input  logic            div_word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_o_valid,
    input  logic            div_o_ready
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   counter;
    logic [XLEN-1:0] acc, quo, dsr_mag;
    logic            neg_q, neg_r, word_q;

    function automatic logic [XLEN-1:0] ext_word(input logic [WLEN-1:0] x, input logic sgn);
        return {{(XLEN-WLEN){sgn & x[WLEN-1]}}, x};
    endfunction

    // Word-mode results are always sign-extended from bit WLEN-1, even for unsigned ops.
    function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] x, input logic wrd);
        return wrd ? {{(XLEN-WLEN){x[WLEN-1]}}, x[WLEN-1:0]} : x;
    endfunction

    logic [XLEN-1:0] op_a, op_b, a_mag, b_mag, min_val;
    logic [XLEN-1:0] early_q, early_r;
    logic            a_neg, b_neg, div_zero, overflow, early, accept;

    always_comb begin
        op_a     = div_word ? ext_word(dividend[WLEN-1:0], div_signed) : dividend;
        op_b     = div_word ? ext_word(divisor[WLEN-1:0], div_signed) : divisor;
        a_neg    = div_signed & op_a[XLEN-1];
        b_neg    = div_signed & op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        min_val  = div_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                            : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (op_b == '0);
        overflow = div_signed & (op_a == min_val) & (op_b == '1);
        early    = div_zero | overflow;
        early_q  = div_zero ? '1 : op_a;
        early_r  = div_zero ? op_a : '0;
    end

    // One restoring step: quo doubles as dividend shifter (MSB out) and quotient collector (LSB in).
    logic [XLEN:0]   rem_shift, diff;
    logic            q_bit;
    logic [XLEN-1:0] acc_nx, quo_nx, fix_q, fix_r;

    always_comb begin
        rem_shift = {acc, quo[XLEN-1]};
        diff      = rem_shift - {1'b0, dsr_mag};
        q_bit     = ~diff[XLEN];
        acc_nx    = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        quo_nx    = {quo[XLEN-2:0], q_bit};
        fix_q     = neg_q ? -quo_nx : quo_nx;
        fix_r     = neg_r ? -acc_nx : acc_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nx    = state;
        div_i_ready = (state == IDLE);
        div_o_valid = (state == DONE);
        accept      = div_valid & div_i_ready & ~div_flush;
        case (state)
            IDLE:    if (accept) state_nx = early ? DONE : CALC;
            CALC:    if (counter == CW'(1)) state_nx = DONE;
            DONE:    if (div_o_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (div_flush) state_nx = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter   <= '0;
            acc       <= '0;
            quo       <= '0;
            dsr_mag   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            word_q    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (state == IDLE && accept) begin
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            word_q  <= div_word;
            dsr_mag <= b_mag;
            acc     <= '0;
            // Word operands are pre-aligned to the top so the same MSB-first step serves both widths.
            quo     <= div_word ? (a_mag << (XLEN - WLEN)) : a_mag;
            counter <= div_word ? CW'(WLEN) : CW'(XLEN);
            if (early) begin
                quotient  <= fin(early_q, div_word);
                remainder <= fin(early_r, div_word);
            end
        end else if (state == CALC && !div_flush) begin
            acc     <= acc_nx;
            quo     <= quo_nx;
            counter <= counter - CW'(1);
            if (counter == CW'(1)) begin
                quotient  <= fin(fix_q, word_q);
                remainder <= fin(fix_r, word_q);
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: scoreboard of expected quotient/remainder/latency
// pushed at accept and compared when the divider presents its result.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_flush, div_valid, div_i_ready, div_signed, div_word;
    logic [63:0] dividend, divisor, quotient, remainder;
    logic        div_o_valid, div_o_ready;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } exp_t;

    exp_t sb[$];

    div_iter #(.XLEN(64), .WLEN(32)) dut (
        .clk(clk), .rst(rst), .div_flush(div_flush), .div_valid(div_valid),
        .div_i_ready(div_i_ready), .div_signed(div_signed), .div_word(div_word),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .div_o_valid(div_o_valid), .div_o_ready(div_o_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic sgn, input logic wrd);
        exp_t        e;
        logic [31:0] a32, b32, q32, r32;
        if (wrd) begin
            a32 = a[31:0];
            b32 = b[31:0];
            e.lat = 33;
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32; e.lat = 1;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = '0; e.lat = 1;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            e.q = {{32{q32[31]}}, q32};
            e.r = {{32{r32[31]}}, r32};
        end else begin
            e.lat = 65;
            if (b == 64'd0) begin
                e.q = '1; e.r = a; e.lat = 1;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                e.q = a; e.r = '0; e.lat = 1;
            end else if (sgn) begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one request, scrambles the inputs while busy, then checks the result against
    // the scoreboard, holds it for `hold` cycles and releases it with a single ready cycle.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic sgn, input logic wrd, input int hold);
        exp_t        e;
        int          lat;
        logic        busy_bad;
        logic [63:0] q0, r0;
        dividend   = a;
        divisor    = b;
        div_signed = sgn;
        div_word   = wrd;
        div_valid  = 1'b1;
        check("ready_before_accept", 64'(div_i_ready), 64'd1);
        sb.push_back(model(a, b, sgn, wrd));
        tick();
        div_valid  = 1'b0;
        dividend   = {$urandom, $urandom};
        divisor    = {$urandom, $urandom};
        div_signed = ~sgn;
        div_word   = ~wrd;
        lat        = 1;
        busy_bad   = 1'b0;
        while (!div_o_valid && lat < 200) begin
            if (div_i_ready) busy_bad = 1'b1;
            if (lat == 3) div_valid = 1'b1;
            tick();
            lat++;
        end
        div_valid = 1'b0;
        e = sb.pop_front();
        if (!div_o_valid) begin
            check("result_timeout", 64'(div_o_valid), 64'd1);
            return;
        end
        check("latency", 64'(lat), 64'(e.lat));
        check("ready_low_busy", 64'(busy_bad), 64'd0);
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        q0 = quotient;
        r0 = remainder;
        busy_bad = 1'b0;
        div_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!div_o_valid || div_i_ready || quotient !== q0 || remainder !== r0) busy_bad = 1'b1;
        end
        if (hold > 0) check("hold_stable", 64'(busy_bad), 64'd0);
        div_o_ready = 1'b1;
        tick();
        div_o_ready = 1'b0;
        div_valid   = 1'b0;
        check("idle_after_ready", {62'd0, div_i_ready, div_o_valid}, 64'b10);
    endtask

    initial begin
        logic [63:0] a, b;
        logic        bad;
        rst = 1'b1; div_flush = 1'b0; div_valid = 1'b0; div_signed = 1'b0; div_word = 1'b0;
        dividend = '0; divisor = '0; div_o_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_state", {62'd0, div_i_ready, div_o_valid}, 64'b10);
        check("rst_quotient", quotient, 64'd0);
        check("rst_remainder", remainder, 64'd0);

        run_op(64'd100, 64'd7, 1'b0, 1'b0, 0);
        run_op(-64'sd7, 64'd2, 1'b1, 1'b0, 0);
        run_op(64'd5, 64'd0, 1'b0, 1'b0, 0);
        run_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 0);
        run_op(64'h1_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 0);
        run_op(64'd12345, 64'd99, 1'b1, 1'b0, 10);
        run_op(64'h0000_0001_8000_0000, 64'h0000_0007_FFFF_FFFF, 1'b1, 1'b1, 0);
        run_op(64'h1234_0000_0064, 64'h5_0000_0000, 1'b0, 1'b1, 0);
        run_op('1, 64'd3, 1'b0, 1'b0, 0);
        run_op('1, 64'd3, 1'b1, 1'b0, 0);
        run_op(64'd7, -64'sd2, 1'b1, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            a = {$urandom, $urandom};
            b = (i % 3 == 0) ? 64'($urandom_range(1, 15)) : {$urandom, $urandom};
            if (i % 4 == 1) b = b >> $urandom_range(1, 60);
            run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end

        // Flush during the 20th CALC cycle, colliding with div_valid and div_o_ready.
        dividend = 64'd1000; divisor = 64'd3; div_signed = 1'b0; div_word = 1'b0;
        div_valid = 1'b1;
        tick();
        div_valid = 1'b0;
        repeat (19) tick();
        div_flush = 1'b1; div_valid = 1'b1; div_o_ready = 1'b1;
        tick();
        div_flush = 1'b0; div_valid = 1'b0; div_o_ready = 1'b0;
        check("flush_calc_idle", {62'd0, div_i_ready, div_o_valid}, 64'b10);
        bad = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (div_o_valid || !div_i_ready) bad = 1'b1;
        end
        check("flush_no_result", 64'(bad), 64'd0);

        // Flush in IDLE beats a simultaneous request.
        div_flush = 1'b1; div_valid = 1'b1;
        tick();
        div_flush = 1'b0; div_valid = 1'b0;
        tick();
        check("flush_blocks_accept", {62'd0, div_i_ready, div_o_valid}, 64'b10);

        // Flush while a result is waiting drops it.
        dividend = 64'd9; divisor = 64'd0; div_valid = 1'b1;
        tick();
        div_valid = 1'b0;
        check("early_out_valid", 64'(div_o_valid), 64'd1);
        div_flush = 1'b1;
        tick();
        div_flush = 1'b0;
        check("flush_done_idle", {62'd0, div_i_ready, div_o_valid}, 64'b10);

        // Reset mid-calculation clears the held result registers too.
        dividend = 64'd1000; divisor = 64'd7; div_valid = 1'b1;
        tick();
        div_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_state", {62'd0, div_i_ready, div_o_valid}, 64'b10);
        check("rst_mid_quotient", quotient, 64'd0);
        check("rst_mid_remainder", remainder, 64'd0);
        run_op(64'd1000, 64'd7, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
